// File: rtl/control_unit_if.sv
// Decode inputs and datapath control lines between the multicycle MIPS control FSM
// (master) and the datapath it steers (slave).
interface control_unit_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       pc_write;
   logic       iord;
   logic       mem_wr;
   logic       ir_wr;
   logic       reg_wr;
   logic [2:0] wr_reg_sel;
   logic [1:0] mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic [1:0] pc_source;
   logic       illegal_op;
   logic [4:0] state;

   modport master (
      input  opcode, funct, zero,
      output pc_write, iord, mem_wr, ir_wr, reg_wr, wr_reg_sel, mem_to_reg,
             alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, state
   );

   modport slave (
      output opcode, funct, zero,
      input  pc_write, iord, mem_wr, ir_wr, reg_wr, wr_reg_sel, mem_to_reg,
             alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, state
   );
endinterface

// File: rtl/control_unit.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back and
// decodes datapath select and write-enable lines from the registered state.
module control_unit (
   input  logic           clk,
   input  logic           reset,
   control_unit_if.master bus
);
   typedef enum logic [4:0] {
      S_RESET      = 5'd0,  S_INIT_SP   = 5'd1,  S_FETCH    = 5'd2,  S_FETCH_WAIT = 5'd3,
      S_DECODE     = 5'd4,  S_R_EXEC    = 5'd5,  S_R_WB     = 5'd6,  S_ADDI_EXEC  = 5'd7,
      S_ADDI_WB    = 5'd8,  S_MEM_ADDR  = 5'd9,  S_LW_READ  = 5'd10, S_LW_WAIT    = 5'd11,
      S_LW_WB      = 5'd12, S_SW_WRITE  = 5'd13, S_BRANCH   = 5'd14, S_JAL_LINK   = 5'd15,
      S_JUMP       = 5'd16, S_JR        = 5'd17
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [2:0] ALU_IDLE = 3'b000, ALU_ADD = 3'b001, ALU_SUB = 3'b010;

   state_t state_r;
   state_t next_state_s;

   // R-type funct to ALU operation; unsupported functs map to idle.
   function automatic logic [2:0] funct_alu_op(input logic [5:0] f);
      case (f)
         6'h20:   return 3'b001;
         6'h22:   return 3'b010;
         6'h24:   return 3'b011;
         6'h25:   return 3'b100;
         6'h2A:   return 3'b101;
         default: return ALU_IDLE;
      endcase
   endfunction

   // State register with synchronous reset that aborts any instruction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_RESET;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state sequencing, including opcode dispatch out of DECODE.
   always_comb begin
      next_state_s = S_FETCH;
      case (state_r)
         S_RESET:      next_state_s = S_INIT_SP;
         S_INIT_SP:    next_state_s = S_FETCH;
         S_FETCH:      next_state_s = S_FETCH_WAIT;
         S_FETCH_WAIT: next_state_s = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_RTYPE: begin
                  if (bus.funct == FN_JR) begin
                     next_state_s = S_JR;
                  end else if (funct_alu_op(bus.funct) != ALU_IDLE) begin
                     next_state_s = S_R_EXEC;
                  end else begin
                     next_state_s = S_FETCH;
                  end
               end
               OP_ADDI:       next_state_s = S_ADDI_EXEC;
               OP_LW, OP_SW:  next_state_s = S_MEM_ADDR;
               OP_BEQ, OP_BNE: next_state_s = S_BRANCH;
               OP_J:          next_state_s = S_JUMP;
               OP_JAL:        next_state_s = S_JAL_LINK;
               default:       next_state_s = S_FETCH;
            endcase
         end
         S_R_EXEC:    next_state_s = S_R_WB;
         S_ADDI_EXEC: next_state_s = S_ADDI_WB;
         S_MEM_ADDR: begin
            if (bus.opcode == OP_LW) begin
               next_state_s = S_LW_READ;
            end else if (bus.opcode == OP_SW) begin
               next_state_s = S_SW_WRITE;
            end else begin
               next_state_s = S_FETCH;
            end
         end
         S_LW_READ:  next_state_s = S_LW_WAIT;
         S_LW_WAIT:  next_state_s = S_LW_WB;
         S_JAL_LINK: next_state_s = S_JUMP;
         default:    next_state_s = S_FETCH;
      endcase
   end

   // Output decode from the registered state; only BRANCH looks at zero.
   always_comb begin
      bus.pc_write   = 1'b0;
      bus.iord       = 1'b0;
      bus.mem_wr     = 1'b0;
      bus.ir_wr      = 1'b0;
      bus.reg_wr     = 1'b0;
      bus.wr_reg_sel = 3'b000;
      bus.mem_to_reg = 2'b00;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.alu_op     = ALU_IDLE;
      bus.pc_source  = 2'b00;
      bus.illegal_op = 1'b0;
      case (state_r)
         S_INIT_SP: begin
            bus.reg_wr = 1'b1; bus.wr_reg_sel = 3'b100; bus.mem_to_reg = 2'b11;
         end
         S_FETCH_WAIT: begin
            bus.ir_wr = 1'b1; bus.alu_src_b = 2'b01; bus.alu_op = ALU_ADD; bus.pc_write = 1'b1;
         end
         S_DECODE: begin
            bus.alu_src_b = 2'b11; bus.alu_op = ALU_ADD;
            bus.illegal_op = (next_state_s == S_FETCH) ? 1'b1 : 1'b0;
         end
         S_R_EXEC: begin
            bus.alu_src_a = 1'b1; bus.alu_op = funct_alu_op(bus.funct);
         end
         S_R_WB: begin
            bus.reg_wr = 1'b1; bus.alu_op = funct_alu_op(bus.funct);
         end
         S_ADDI_EXEC, S_MEM_ADDR: begin
            bus.alu_src_a = 1'b1; bus.alu_src_b = 2'b10; bus.alu_op = ALU_ADD;
         end
         S_ADDI_WB: begin
            bus.reg_wr = 1'b1; bus.wr_reg_sel = 3'b001;
         end
         S_LW_READ, S_LW_WAIT: bus.iord = 1'b1;
         S_LW_WB: begin
            bus.reg_wr = 1'b1; bus.wr_reg_sel = 3'b001; bus.mem_to_reg = 2'b01;
         end
         S_SW_WRITE: begin
            bus.iord = 1'b1; bus.mem_wr = 1'b1;
         end
         S_BRANCH: begin
            bus.alu_src_a = 1'b1; bus.alu_op = ALU_SUB; bus.pc_source = 2'b01;
            if (bus.opcode == OP_BEQ) begin
               bus.pc_write = bus.zero;
            end else if (bus.opcode == OP_BNE) begin
               bus.pc_write = ~bus.zero;
            end else begin
               bus.pc_write = 1'b0;
            end
         end
         S_JAL_LINK: begin
            bus.reg_wr = 1'b1; bus.wr_reg_sel = 3'b011; bus.mem_to_reg = 2'b10;
         end
         S_JUMP: begin
            bus.pc_source = 2'b10; bus.pc_write = 1'b1;
         end
         S_JR: begin
            bus.pc_source = 2'b11; bus.pc_write = 1'b1;
         end
         default: bus.illegal_op = 1'b0;
      endcase
   end

   assign bus.state = state_r;
endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: walks each instruction class
// cycle by cycle and compares every control output against hand-derived vectors.
module tb_control_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   control_unit_if bus();

   control_unit dut (.clk(clk), .reset(reset), .bus(bus.master));

   always #5 clk = ~clk;

   logic [23:0] e_reset, e_init, e_fetch, e_fw, e_dec;

   // {state, pc_write, iord, mem_wr, ir_wr, reg_wr, wr_reg_sel, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op}
   function automatic logic [23:0] mk(input logic [4:0] st, input logic pw, input logic io,
                                      input logic mw, input logic irw, input logic rw,
                                      input logic [2:0] wrs, input logic [1:0] m2r,
                                      input logic asa, input logic [1:0] asb,
                                      input logic [2:0] aop, input logic [1:0] pcs,
                                      input logic ill);
      return {st, pw, io, mw, irw, rw, wrs, m2r, asa, asb, aop, pcs, ill};
   endfunction

   function automatic logic [23:0] obs();
      return {bus.state, bus.pc_write, bus.iord, bus.mem_wr, bus.ir_wr, bus.reg_wr,
              bus.wr_reg_sel, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
              bus.pc_source, bus.illegal_op};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [23:0] seq[$];
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (obs() !== e_reset) begin
            errors++;
            $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs(), e_reset);
         end
      end
      reset = 1'b0;
      seq = '{e_init, e_fetch};
      for (int i = 0; i < seq.size(); i++) begin
         step();
         checks++;
         if (obs() !== seq[i]) begin
            errors++;
            $display("FAIL reset_release step %0d: got %h expected %h", i, obs(), seq[i]);
         end
      end
   endtask

   task automatic test_rtype(input logic [5:0] fn, input logic [2:0] aop);
      logic [23:0] seq[$];
      bus.opcode = 6'h00; bus.funct = fn;
      seq = '{e_fetch, e_fw, e_dec,
              mk(5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1, 2'b00, aop, 2'b00, 1'b0),
              mk(5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 1'b0, 2'b00, aop, 2'b00, 1'b0),
              e_fetch};
      for (int i = 0; i < seq.size(); i++) begin
         checks++;
         if (obs() !== seq[i]) begin
            errors++;
            $display("FAIL rtype funct=%h step %0d: got %h expected %h", fn, i, obs(), seq[i]);
         end
         if (i < seq.size() - 1) step();
      end
   endtask

   task automatic test_addi();
      logic [23:0] seq[$];
      bus.opcode = 6'h08; bus.funct = 6'h3F;
      seq = '{e_fetch, e_fw, e_dec,
              mk(5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1, 2'b10, 3'b001, 2'b00, 1'b0),
              mk(5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0),
              e_fetch};
      for (int i = 0; i < seq.size(); i++) begin
         checks++;
         if (obs() !== seq[i]) begin
            errors++;
            $display("FAIL addi step %0d: got %h expected %h", i, obs(), seq[i]);
         end
         if (i < seq.size() - 1) step();
      end
   endtask

   task automatic test_lw();
      logic [23:0] seq[$];
      bus.opcode = 6'h23; bus.funct = 6'h00;
      seq = '{e_fetch, e_fw, e_dec,
              mk(5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1, 2'b10, 3'b001, 2'b00, 1'b0),
              mk(5'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0),
              mk(5'd11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0),
              mk(5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 2'b01, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0),
              e_fetch};
      for (int i = 0; i < seq.size(); i++) begin
         checks++;
         if (obs() !== seq[i]) begin
            errors++;
            $display("FAIL lw step %0d: got %h expected %h", i, obs(), seq[i]);
         end
         if (i < seq.size() - 1) step();
      end
   endtask

   task automatic test_branch(input logic [5:0] op, input logic z, input logic pw);
      logic [23:0] seq[$];
      bus.opcode = op; bus.funct = 6'h00; bus.zero = z;
      seq = '{e_fetch, e_fw, e_dec,
              mk(5'd14, pw, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1, 2'b00, 3'b010, 2'b01, 1'b0),
              e_fetch};
      for (int i = 0; i < seq.size(); i++) begin
         checks++;
         if (obs() !== seq[i]) begin
            errors++;
            $display("FAIL branch op=%h zero=%b step %0d: got %h expected %h", op, z, i, obs(), seq[i]);
         end
         if (i < seq.size() - 1) step();
      end
      bus.zero = 1'b0;
   endtask

   task automatic test_jal();
      logic [23:0] seq[$];
      bus.opcode = 6'h03; bus.funct = 6'h00;
      seq = '{e_fetch, e_fw, e_dec,
              mk(5'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 2'b10, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0),
              mk(5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 2'b00, 3'b000, 2'b10, 1'b0),
              e_fetch};
      for (int i = 0; i < seq.size(); i++) begin
         checks++;
         if (obs() !== seq[i]) begin
            errors++;
            $display("FAIL jal step %0d: got %h expected %h", i, obs(), seq[i]);
         end
         if (i < seq.size() - 1) step();
      end
   endtask

   task automatic test_jr();
      logic [23:0] seq[$];
      bus.opcode = 6'h00; bus.funct = 6'h08;
      seq = '{e_fetch, e_fw, e_dec,
              mk(5'd17, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 2'b00, 3'b000, 2'b11, 1'b0),
              e_fetch};
      for (int i = 0; i < seq.size(); i++) begin
         checks++;
         if (obs() !== seq[i]) begin
            errors++;
            $display("FAIL jr step %0d: got %h expected %h", i, obs(), seq[i]);
         end
         if (i < seq.size() - 1) step();
      end
   endtask

   task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn);
      logic [23:0] seq[$];
      bus.opcode = op; bus.funct = fn;
      seq = '{e_fetch, e_fw,
              mk(5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 2'b11, 3'b001, 2'b00, 1'b1),
              e_fetch};
      for (int i = 0; i < seq.size(); i++) begin
         checks++;
         if (obs() !== seq[i]) begin
            errors++;
            $display("FAIL illegal op=%h funct=%h step %0d: got %h expected %h", op, fn, i, obs(), seq[i]);
         end
         if (i < seq.size() - 1) step();
      end
   endtask

   task automatic test_reset_mid_sw();
      logic [23:0] seq[$];
      bus.opcode = 6'h2B; bus.funct = 6'h00;
      seq = '{e_fetch, e_fw, e_dec,
              mk(5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b1, 2'b10, 3'b001, 2'b00, 1'b0),
              mk(5'd13, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0),
              e_reset, e_init, e_fetch};
      for (int i = 0; i < seq.size(); i++) begin
         checks++;
         if (obs() !== seq[i]) begin
            errors++;
            $display("FAIL reset_mid_sw step %0d: got %h expected %h", i, obs(), seq[i]);
         end
         reset = (i == 4) ? 1'b1 : 1'b0;
         if (i < seq.size() - 1) step();
      end
   endtask

   initial begin
      bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0;
      e_reset = 24'h000000;
      e_init  = mk(5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 2'b11, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
      e_fetch = mk(5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
      e_fw    = mk(5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0, 2'b01, 3'b001, 2'b00, 1'b0);
      e_dec   = mk(5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0, 2'b11, 3'b001, 2'b00, 1'b0);

      test_reset();
      test_rtype(6'h22, 3'b010);
      test_rtype(6'h2A, 3'b101);
      test_rtype(6'h24, 3'b011);
      test_addi();
      test_lw();
      test_branch(6'h04, 1'b1, 1'b1);
      test_branch(6'h05, 1'b1, 1'b0);
      test_branch(6'h04, 1'b0, 1'b0);
      test_branch(6'h05, 1'b0, 1'b1);
      test_jal();
      test_jr();
      test_illegal(6'h3F, 6'h00);
      test_illegal(6'h00, 6'h3F);
      test_reset_mid_sw();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/control_unit.md
# control_unit

Multicycle MIPS control FSM driving the datapath's select and write-enable lines, including the 3-bit write-register mux select that picks the destination register for the register bank (rd, rt, $31, $29). It sits upstream of the write-register mux, ALU, memory and PC. It decodes opcode/funct from the instruction register and sequences fetch, decode, execute, memory and write-back over 4 to 7 cycles per instruction.

## Interface

- No parameters. SP init constant 227 and all encodings are fixed.
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (valid in BRANCH)
- pc_write  out  1  PC load enable
- iord  out  1  memory address: 0=PC, 1=ALUOut
- mem_wr  out  1  memory write (0 = read)
- ir_wr  out  1  IR load enable
- reg_wr  out  1  register bank write enable
- wr_reg_sel  out  3  write-register mux select: 000=rd, 001=rt, 011=$31, 100=$29; 010 never driven
- mem_to_reg  out  2  write data: 00=ALUOut, 01=MDR, 10=PC, 11=constant 227
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=4, 10=signext(imm), 11=signext(imm)<<2
- alu_op  out  3  001 ADD, 010 SUB, 011 AND, 100 OR, 101 SLT, 000 idle
- pc_source  out  2  00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],00}, 11=A
- illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct
- state  out  5  current state code, for debug

## Operation

- Outputs are decoded combinationally from the registered state. Only pc_write in BRANCH also depends on zero and opcode.
- Every output not listed for a state is 0.
- RESET: all outputs 0. Next state is INIT_SP.
- INIT_SP: reg_wr=1, wr_reg_sel=100, mem_to_reg=11. Next is FETCH.
- FETCH: iord=0 (memory read at PC). Next is FETCH_WAIT.
- FETCH_WAIT: ir_wr=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00, pc_write=1. Next is DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut). Next state by opcode:
  - 0x00 with funct 0x20/0x22/0x24/0x25/0x2A goes to R_EXEC; funct 0x08 goes to JR.
  - 0x08 goes to ADDI_EXEC.
  - 0x23 and 0x2B go to MEM_ADDR.
  - 0x04 and 0x05 go to BRANCH.
  - 0x02 goes to JUMP; 0x03 goes to JAL_LINK.
  - Anything else goes to FETCH, with illegal_op=1 during DECODE.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op from funct (add→ADD, sub→SUB, and→AND, or→OR, slt→SLT). Next is R_WB.
- R_WB: reg_wr=1, wr_reg_sel=000, mem_to_reg=00, alu_op held as in R_EXEC. Next is FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, ADD. Next is ADDI_WB.
- ADDI_WB: reg_wr=1, wr_reg_sel=001, mem_to_reg=00. Next is FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Next is LW_READ for lw, SW_WRITE for sw.
- LW_READ: iord=1. Next is LW_WAIT.
- LW_WAIT: iord=1. Next is LW_WB.
- LW_WB: reg_wr=1, wr_reg_sel=001, mem_to_reg=01. Next is FETCH.
- SW_WRITE: iord=1, mem_wr=1. Next is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01, pc_write = zero for beq, ~zero for bne. Next is FETCH.
- JAL_LINK: reg_wr=1, wr_reg_sel=011, mem_to_reg=10 (PC already holds PC+4). Next is JUMP.
- JUMP: pc_source=10, pc_write=1. Next is FETCH.
- JR: pc_source=11, pc_write=1. Next is FETCH.

## Timing

- reset is sampled on each rising edge. If high, state becomes RESET at that edge, regardless of the current state.
- Reset mid-instruction aborts it. mem_wr, reg_wr and pc_write are 0 from the edge that samples reset.
- The state before the first reset edge is undefined.
- After reset falls: INIT_SP for 1 cycle, then FETCH. The first instruction fetch starts 2 cycles after reset deassertion.
- Cycles per instruction, FETCH through last state inclusive:
  - R-type, addi, sw, jal: 5
  - lw: 7
  - beq, bne, j, jr: 4
  - unsupported: 3
- Memory read latency is one cycle: data is valid in the state after the address state (FETCH_WAIT, LW_WAIT).
- reg_wr and mem_wr are single-cycle pulses; no state asserts both.
- zero is sampled only in BRANCH, combinationally, within the same cycle.

## Test plan

- Reset held 3 cycles then released → all outputs 0 while held. Next cycle: reg_wr=1, wr_reg_sel=100, mem_to_reg=11. Then state=FETCH.
- opcode=0x00, funct=0x22 → R_EXEC shows alu_op=010. R_WB shows reg_wr=1, wr_reg_sel=000. Back to FETCH after 5 cycles.
- opcode=0x23 → 7 cycles. LW_READ and LW_WAIT have iord=1. LW_WB has reg_wr=1, wr_reg_sel=001, mem_to_reg=01.
- opcode=0x04 with zero=1 → pc_write=1, pc_source=01 in BRANCH. opcode=0x05 with zero=1 → pc_write=0.
- opcode=0x03 → JAL_LINK has wr_reg_sel=011, mem_to_reg=10, reg_wr=1. JUMP has pc_source=10. Then FETCH.
- opcode=0x3F → illegal_op pulses 1 cycle in DECODE, then FETCH. Separately, reset asserted during SW_WRITE → mem_wr=0 after the next edge, state=RESET.
